// File: rtl/uarc_pkg.sv
// Shared types for the UARC bus engines: op codes, completion status,
// sender FSM states and the word-width helper.
package uarc_pkg;

   typedef enum logic [1:0] {
      OP_KILL   = 2'd0,
      OP_INCEPT = 2'd1,
      OP_SEND   = 2'd2,
      OP_STREAM = 2'd3
   } uarc_op_t;

   typedef enum logic [1:0] {
      STAT_OK      = 2'd0,
      STAT_BAD_BUS = 2'd1,
      STAT_TIMEOUT = 2'd2
   } uarc_status_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_DRIVE,
      S_STREAM_GAP,
      S_RESP
   } sender_state_t;

   function automatic int word_width(input int mag);
      return 1 << mag;
   endfunction

   // Strobe vector bit order: [0]=kill [1]=incept [2]=send [3]=stream
   function automatic logic [3:0] op_strobe(input uarc_op_t op);
      return 4'b0001 << op;
   endfunction

endpackage

// File: rtl/onehot_decoder.sv
// Index to one-hot decoder with an in-range flag; the inverse of
// priority_encoder. Indices at or above N give all-zero and o_in_range=0.
module onehot_decoder #(
   parameter int IDX_W = 32,
   parameter int N     = 4
) (
   input  logic [IDX_W-1:0] i_idx,
   output logic [N-1:0]     o_onehot,
   output logic             o_in_range
);

   // Compare in a width that holds both the index and N without truncation.
   localparam int CW = (IDX_W > 32) ? IDX_W + 1 : 33;

   logic [CW-1:0] w_idx;

   assign w_idx = CW'(i_idx);

   always_comb begin
      o_onehot = '0;
      for (int i = 0; i < N; i++) begin
         o_onehot[i] = (w_idx == CW'(i));
      end
   end

   assign o_in_range = (w_idx < CW'(N));

endmodule

// File: rtl/uarc_sender.sv
// Outbound UARC bus engine: drives one kill/incept/send/stream onto a selected
// bus until its ack returns. Optional abort timer: UARC_SENDER_TIMEOUT_EN.
//
// state        | meaning
// S_IDLE       | ready for a new request
// S_DRIVE      | strobe + enable held, waiting for the matching ack
// S_STREAM_GAP | stream word acked, bus still owned, waiting for next word
// S_RESP       | one-cycle completion pulse back to the core
module uarc_sender
   import uarc_pkg::*;
#(
   parameter int WORD_MAG       = 5,
   parameter int TOTAL_BUSES    = 1,
   parameter int BUS_SEL_WIDTH  = word_width(WORD_MAG),
   parameter int TIMEOUT_CYCLES = 1024,
   localparam int WORD_WIDTH    = word_width(WORD_MAG)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  uarc_op_t                 req_op,
   input  logic [BUS_SEL_WIDTH-1:0] req_bus,
   input  logic [WORD_WIDTH-1:0]    req_data,
   input  logic                     req_last,
   input  logic [WORD_WIDTH-1:0]    req_incept_permission,
   input  logic [WORD_WIDTH-1:0]    req_incept_address,
   input  logic [WORD_WIDTH-1:0]    self_permission,
   input  logic [WORD_WIDTH-1:0]    self_address,
   output logic                     resp_valid,
   output uarc_status_t             resp_status,
   output logic                     global_kill,
   output logic                     global_incept,
   output logic                     global_send,
   output logic                     global_stream,
   output logic [WORD_WIDTH-1:0]    global_data,
   output logic [WORD_WIDTH-1:0]    global_self_permission,
   output logic [WORD_WIDTH-1:0]    global_self_address,
   output logic [WORD_WIDTH-1:0]    global_incept_permission,
   output logic [WORD_WIDTH-1:0]    global_incept_address,
   output logic [TOTAL_BUSES-1:0]   sender_enables,
   input  logic [TOTAL_BUSES-1:0]   sender_kill_acks,
   input  logic [TOTAL_BUSES-1:0]   sender_incept_acks,
   input  logic [TOTAL_BUSES-1:0]   sender_send_acks,
   input  logic [TOTAL_BUSES-1:0]   sender_stream_acks
);

   sender_state_t          r_state, w_state_nxt;
   uarc_op_t               r_op, w_op_nxt;
   logic                   r_last, w_last_nxt;
   logic [3:0]             r_strobes, w_strobes_nxt;
   logic [TOTAL_BUSES-1:0] r_enables, w_enables_nxt;
   logic [WORD_WIDTH-1:0]  r_data, w_data_nxt;
   logic [WORD_WIDTH-1:0]  r_inc_perm, w_inc_perm_nxt;
   logic [WORD_WIDTH-1:0]  r_inc_addr, w_inc_addr_nxt;
   logic [WORD_WIDTH-1:0]  r_self_perm, w_self_perm_nxt;
   logic [WORD_WIDTH-1:0]  r_self_addr, w_self_addr_nxt;
   logic                   r_resp_valid, w_resp_valid_nxt;
   uarc_status_t           r_status, w_status_nxt;

   logic [TOTAL_BUSES-1:0] w_onehot;
   logic                   w_in_range;
   logic [TOTAL_BUSES-1:0] w_ack_vec;
   logic                   w_ack_hit;
   logic                   w_timeout;

   onehot_decoder #(
      .IDX_W (BUS_SEL_WIDTH),
      .N     (TOTAL_BUSES)
   ) u_bus_dec (
      .i_idx      (req_bus),
      .o_onehot   (w_onehot),
      .o_in_range (w_in_range)
   );

   always_comb begin
      w_ack_vec = '0;
      case (r_op)
         OP_KILL:   w_ack_vec = sender_kill_acks;
         OP_INCEPT: w_ack_vec = sender_incept_acks;
         OP_SEND:   w_ack_vec = sender_send_acks;
         OP_STREAM: w_ack_vec = sender_stream_acks;
      endcase
   end

   // The owned bus is exactly the set enable bit, so masking picks its ack.
   assign w_ack_hit = |(w_ack_vec & r_enables);

   assign req_ready = (r_state == S_IDLE) ||
                      (r_state == S_STREAM_GAP && req_op == OP_STREAM);

`ifdef UARC_SENDER_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

   logic [TW-1:0] r_tmr;

   // Down-counter reloaded on every entry to DRIVE or STREAM_GAP.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_tmr <= '0;
      end else if (w_state_nxt != r_state &&
                   (w_state_nxt == S_DRIVE || w_state_nxt == S_STREAM_GAP)) begin
         r_tmr <= TW'(TIMEOUT_CYCLES - 1);
      end else if (r_tmr != '0) begin
         r_tmr <= r_tmr - 1'b1;
      end
   end

   assign w_timeout = (r_state == S_DRIVE || r_state == S_STREAM_GAP) && (r_tmr == '0);
`else
   localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

   assign w_timeout = 1'b0;
`endif

   always_comb begin
      w_state_nxt      = r_state;
      w_op_nxt         = r_op;
      w_last_nxt       = r_last;
      w_strobes_nxt    = r_strobes;
      w_enables_nxt    = r_enables;
      w_data_nxt       = r_data;
      w_inc_perm_nxt   = r_inc_perm;
      w_inc_addr_nxt   = r_inc_addr;
      w_self_perm_nxt  = r_self_perm;
      w_self_addr_nxt  = r_self_addr;
      w_resp_valid_nxt = 1'b0;
      w_status_nxt     = r_status;
      case (r_state)
         S_IDLE: begin
            if (req_valid) begin
               w_op_nxt        = req_op;
               w_last_nxt      = req_last;
               w_data_nxt      = req_data;
               w_inc_perm_nxt  = req_incept_permission;
               w_inc_addr_nxt  = req_incept_address;
               w_self_perm_nxt = self_permission;
               w_self_addr_nxt = self_address;
               if (w_in_range) begin
                  w_state_nxt   = S_DRIVE;
                  w_enables_nxt = w_onehot;
                  w_strobes_nxt = op_strobe(req_op);
               end else begin
                  w_state_nxt      = S_RESP;
                  w_resp_valid_nxt = 1'b1;
                  w_status_nxt     = STAT_BAD_BUS;
               end
            end
         end
         S_DRIVE: begin
            if (w_ack_hit) begin
               w_strobes_nxt = '0;
               if (r_op == OP_STREAM && !r_last) begin
                  w_state_nxt = S_STREAM_GAP;
               end else begin
                  w_state_nxt      = S_RESP;
                  w_enables_nxt    = '0;
                  w_resp_valid_nxt = 1'b1;
                  w_status_nxt     = STAT_OK;
               end
            end else if (w_timeout) begin
               w_state_nxt      = S_RESP;
               w_strobes_nxt    = '0;
               w_enables_nxt    = '0;
               w_resp_valid_nxt = 1'b1;
               w_status_nxt     = STAT_TIMEOUT;
            end
         end
         S_STREAM_GAP: begin
            if (req_valid && req_op == OP_STREAM) begin
               w_state_nxt   = S_DRIVE;
               w_data_nxt    = req_data;
               w_last_nxt    = req_last;
               w_strobes_nxt = op_strobe(OP_STREAM);
            end else if (w_timeout) begin
               w_state_nxt      = S_RESP;
               w_enables_nxt    = '0;
               w_resp_valid_nxt = 1'b1;
               w_status_nxt     = STAT_TIMEOUT;
            end
         end
         S_RESP: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= S_IDLE;
         r_op         <= OP_KILL;
         r_last       <= 1'b0;
         r_strobes    <= '0;
         r_enables    <= '0;
         r_data       <= '0;
         r_inc_perm   <= '0;
         r_inc_addr   <= '0;
         r_self_perm  <= '0;
         r_self_addr  <= '0;
         r_resp_valid <= 1'b0;
         r_status     <= STAT_OK;
      end else begin
         r_state      <= w_state_nxt;
         r_op         <= w_op_nxt;
         r_last       <= w_last_nxt;
         r_strobes    <= w_strobes_nxt;
         r_enables    <= w_enables_nxt;
         r_data       <= w_data_nxt;
         r_inc_perm   <= w_inc_perm_nxt;
         r_inc_addr   <= w_inc_addr_nxt;
         r_self_perm  <= w_self_perm_nxt;
         r_self_addr  <= w_self_addr_nxt;
         r_resp_valid <= w_resp_valid_nxt;
         r_status     <= w_status_nxt;
      end
   end

   assign global_kill              = r_strobes[0];
   assign global_incept            = r_strobes[1];
   assign global_send              = r_strobes[2];
   assign global_stream            = r_strobes[3];
   assign global_data              = r_data;
   assign global_self_permission   = r_self_perm;
   assign global_self_address      = r_self_addr;
   assign global_incept_permission = r_inc_perm;
   assign global_incept_address    = r_inc_addr;
   assign sender_enables           = r_enables;
   assign resp_valid               = r_resp_valid;
   assign resp_status              = r_status;

endmodule

// File: tb/tb_uarc_sender.sv
// Bench for uarc_sender: a transaction-level owner/strobe model checked every
// cycle, plus literal expectations for the directed scenarios.
module tb_uarc_sender;
   import uarc_pkg::*;

   localparam int NB  = 4;
   localparam int TMO = 8;
`ifdef UARC_SENDER_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_b = 1'b0;
   logic req_valid = 1'b0;
   logic req_ready;
   uarc_op_t req_op = OP_KILL;
   logic [31:0] req_bus = '0, req_data = '0;
   logic req_last = 1'b0;
   logic [31:0] req_incept_permission = '0, req_incept_address = '0;
   logic [31:0] self_permission = 32'hA5A5_0001, self_address = 32'h0000_0C00;
   logic resp_valid;
   uarc_status_t resp_status;
   logic global_kill, global_incept, global_send, global_stream;
   logic [31:0] global_data, global_self_permission, global_self_address;
   logic [31:0] global_incept_permission, global_incept_address;
   logic [NB-1:0] sender_enables;
   logic [NB-1:0] sender_kill_acks = '0, sender_incept_acks = '0;
   logic [NB-1:0] sender_send_acks = '0, sender_stream_acks = '0;

   uarc_sender #(
      .WORD_MAG(5), .TOTAL_BUSES(NB), .BUS_SEL_WIDTH(32), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk), .reset(rst_b),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_bus(req_bus), .req_data(req_data), .req_last(req_last),
      .req_incept_permission(req_incept_permission),
      .req_incept_address(req_incept_address),
      .self_permission(self_permission), .self_address(self_address),
      .resp_valid(resp_valid), .resp_status(resp_status),
      .global_kill(global_kill), .global_incept(global_incept),
      .global_send(global_send), .global_stream(global_stream),
      .global_data(global_data),
      .global_self_permission(global_self_permission),
      .global_self_address(global_self_address),
      .global_incept_permission(global_incept_permission),
      .global_incept_address(global_incept_address),
      .sender_enables(sender_enables),
      .sender_kill_acks(sender_kill_acks), .sender_incept_acks(sender_incept_acks),
      .sender_send_acks(sender_send_acks), .sender_stream_acks(sender_stream_acks)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc_n = 0;
   always @(posedge clk) cyc_n <= cyc_n + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: which bus is owned, whether its strobe is up, and a pending response.
   int           m_own = -1;
   bit           m_strobe = 1'b0;
   uarc_op_t     m_op = OP_KILL;
   bit           m_last = 1'b0;
   logic [31:0]  m_data = '0, m_ip = '0, m_ia = '0, m_sp = '0, m_sa = '0;
   bit           m_resp = 1'b0;
   uarc_status_t m_stat = STAT_OK;
   int           m_wait = 0;

   function automatic bit ack_of(input uarc_op_t op, input int bus);
      case (op)
         OP_KILL:   return sender_kill_acks[bus];
         OP_INCEPT: return sender_incept_acks[bus];
         OP_SEND:   return sender_send_acks[bus];
         default:   return sender_stream_acks[bus];
      endcase
   endfunction

   always @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         m_own = -1; m_strobe = 0; m_resp = 0; m_stat = STAT_OK; m_wait = 0;
         m_data = '0; m_ip = '0; m_ia = '0; m_sp = '0; m_sa = '0;
      end else if (m_resp) begin
         m_resp = 0;
      end else if (m_own < 0) begin
         if (req_valid) begin
            m_op = req_op; m_last = req_last; m_data = req_data;
            m_ip = req_incept_permission; m_ia = req_incept_address;
            m_sp = self_permission; m_sa = self_address;
            if (req_bus < NB) begin
               m_own = int'(req_bus); m_strobe = 1; m_wait = 0;
            end else begin
               m_resp = 1; m_stat = STAT_BAD_BUS;
            end
         end
      end else if (m_strobe && ack_of(m_op, m_own)) begin
         m_strobe = 0; m_wait = 0;
         if (!(m_op == OP_STREAM && !m_last)) begin
            m_own = -1; m_resp = 1; m_stat = STAT_OK;
         end
      end else if (!m_strobe && req_valid && req_op == OP_STREAM) begin
         m_data = req_data; m_last = req_last; m_strobe = 1; m_wait = 0;
      end else begin
         m_wait++;
         if (TMO_EN && m_wait >= TMO) begin
            m_own = -1; m_strobe = 0; m_resp = 1; m_stat = STAT_TIMEOUT;
         end
      end
   end

   // Per-cycle compare plus counters used by the literal checks.
   logic [3:0] e_str, e_en;
   logic       e_rdy;
   int n_resp = 0, n_send_cyc = 0, n_stream_rise = 0, n_any_str = 0, resp_cyc = 0;
   uarc_status_t last_stat = STAT_OK;
   logic [31:0] last_send_data = '0;
   logic prev_stream = 1'b0;
   logic [31:0] stream_words[$];

   always @(negedge clk) begin
      e_str = m_strobe ? (4'b0001 << m_op) : 4'b0000;
      e_en  = (m_own >= 0) ? (4'b0001 << m_own) : 4'b0000;
      if (m_resp) e_rdy = 1'b0;
      else if (m_own < 0) e_rdy = 1'b1;
      else if (m_strobe) e_rdy = 1'b0;
      else e_rdy = (req_op == OP_STREAM);
      chk("strobes", {global_stream, global_send, global_incept, global_kill}, e_str);
      chk("enables", sender_enables, e_en);
      chk("resp_valid", resp_valid, m_resp);
      chk("req_ready", req_ready, e_rdy);
      if (m_resp) chk("resp_status", resp_status, m_stat);
      if (m_strobe) begin
         chk("global_data", global_data, m_data);
         chk("self_perm", global_self_permission, m_sp);
         chk("self_addr", global_self_address, m_sa);
         chk("incept_perm", global_incept_permission, m_ip);
         chk("incept_addr", global_incept_address, m_ia);
      end
      if (resp_valid) begin
         n_resp++; resp_cyc = cyc_n; last_stat = resp_status;
      end
      if (global_send) begin
         n_send_cyc++; last_send_data = global_data;
      end
      if (global_kill | global_incept | global_send | global_stream) n_any_str++;
      if (global_stream && !prev_stream) begin
         n_stream_rise++; stream_words.push_back(global_data);
      end
      prev_stream = global_stream;
   end

   int acc_cyc = 0;

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic issue(input uarc_op_t op, input logic [31:0] bus,
                        input logic [31:0] data, input bit last);
      bit rdy;
      bit done;
      done = 1'b0;
      req_valid = 1'b1; req_op = op; req_bus = bus; req_data = data; req_last = last;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk);
         rdy = req_ready;
         acc_cyc = cyc_n;
         @(posedge clk);
         #2;
         done = rdy;
      end
      req_valid = 1'b0;
      if (!done) begin
         checks++; errors++;
         $display("FAIL accept_wait: got no accept expected accept within 40 cycles");
      end
   endtask

   task automatic set_ack(input uarc_op_t op, input int bus, input bit v);
      case (op)
         OP_KILL:   sender_kill_acks[bus] = v;
         OP_INCEPT: sender_incept_acks[bus] = v;
         OP_SEND:   sender_send_acks[bus] = v;
         default:   sender_stream_acks[bus] = v;
      endcase
   endtask

   task automatic ack_pulse(input uarc_op_t op, input int bus, input int dly);
      cyc(dly);
      set_ack(op, bus, 1'b1);
      cyc(1);
      set_ack(op, bus, 1'b0);
   endtask

   task automatic wait_resp(input int max);
      int n0;
      int k;
      n0 = n_resp;
      k = 0;
      while (n_resp == n0 && k < max) begin
         cyc(1);
         k++;
      end
      if (n_resp == n0) begin
         checks++; errors++;
         $display("FAIL resp_wait: got no resp expected resp within %0d cycles", max);
      end
   endtask

   int r0, s0, a0, a1, a2;

   initial begin
      cyc(2);
      @(negedge clk);
      chk("rst_ready", req_ready, 1);
      chk("rst_strobes_en", {resp_valid, global_kill, global_incept, global_send,
                             global_stream, sender_enables}, 0);
      chk("rst_data", global_data, 0);
      chk("rst_self_addr", global_self_address, 0);
      cyc(1);
      rst_b = 1'b1;
      cyc(1);

      // SEND bus 0, ack sampled on the third DRIVE edge
      s0 = n_send_cyc; r0 = n_resp;
      issue(OP_SEND, 0, 32'hDEAD_BEEF, 0);
      ack_pulse(OP_SEND, 0, 2);
      wait_resp(10);
      cyc(1);
      chk("send_strobe_cycles", n_send_cyc - s0, 3);
      chk("send_resp_count", n_resp - r0, 1);
      chk("send_status", last_stat, STAT_OK);
      chk("send_data_seen", last_send_data, 32'hDEAD_BEEF);

      // KILL bus 2: foreign acks are ignored
      r0 = n_resp;
      issue(OP_KILL, 2, 0, 0);
      ack_pulse(OP_SEND, 2, 1);
      ack_pulse(OP_KILL, 1, 0);
      ack_pulse(OP_INCEPT, 2, 0);
      cyc(1);
      chk("kill_no_early_resp", n_resp - r0, 0);
      chk("kill_enables_held", sender_enables, 4'b0100);
      ack_pulse(OP_KILL, 2, 0);
      wait_resp(5);
      chk("kill_status", last_stat, STAT_OK);

      // STREAM 1,2,3 on bus 1 with a rejected KILL in the first gap
      r0 = n_resp; s0 = n_stream_rise; stream_words.delete();
      issue(OP_STREAM, 1, 32'd1, 0);
      ack_pulse(OP_STREAM, 1, 1);
      req_valid = 1'b1; req_op = OP_KILL; req_bus = 0;
      @(negedge clk);
      chk("gap_kill_ready", req_ready, 0);
      chk("gap_enable", sender_enables, 4'b0010);
      chk("gap_stream_low", global_stream, 0);
      cyc(1);
      issue(OP_STREAM, 3, 32'd2, 0);
      ack_pulse(OP_STREAM, 1, 0);
      issue(OP_STREAM, 0, 32'd3, 1);
      ack_pulse(OP_STREAM, 1, 2);
      wait_resp(5);
      chk("stream_strobes", n_stream_rise - s0, 3);
      chk("stream_resp_count", n_resp - r0, 1);
      chk("stream_status", last_stat, STAT_OK);
      chk("stream_words", stream_words.size(), 3);
      for (int i = 0; i < stream_words.size() && i < 3; i++)
         chk("stream_word_val", stream_words[i], i + 1);

      // Out-of-range bus
      a0 = n_any_str;
      issue(OP_SEND, 7, 32'h1234, 0);
      wait_resp(4);
      chk("badbus_status", last_stat, STAT_BAD_BUS);
      chk("badbus_latency", resp_cyc - acc_cyc, 1);
      chk("badbus_no_strobe", n_any_str - a0, 0);

      // Acks pre-held: minimum turnaround and back-to-back interval
      sender_incept_acks[3] = 1'b1; sender_send_acks[1] = 1'b1;
      req_incept_permission = 32'h0000_00F0; req_incept_address = 32'h4000_0000;
      issue(OP_INCEPT, 3, 32'h0, 0);
      a1 = acc_cyc;
      issue(OP_SEND, 1, 32'hCAFE_F00D, 0);
      a2 = acc_cyc;
      wait_resp(5);
      chk("b2b_interval", a2 - a1, 3);
      chk("min_turnaround", resp_cyc - a2, 2);
      chk("min_status", last_stat, STAT_OK);
      sender_incept_acks = '0; sender_send_acks = '0;
      cyc(1);

      // Asynchronous reset in the middle of DRIVE
      r0 = n_resp;
      issue(OP_SEND, 1, 32'h5555_AAAA, 0);
      cyc(1);
      #1 rst_b = 1'b0;
      #1;
      chk("arst_enables", sender_enables, 0);
      chk("arst_strobe", global_send, 0);
      chk("arst_data", global_data, 0);
      cyc(2);
      rst_b = 1'b1;
      cyc(2);
      chk("arst_no_resp", n_resp - r0, 0);
      issue(OP_KILL, 0, 0, 0);
      ack_pulse(OP_KILL, 0, 1);
      wait_resp(5);
      chk("arst_next_ok", last_stat, STAT_OK);
      chk("arst_next_count", n_resp - r0, 1);

`ifdef UARC_SENDER_TIMEOUT_EN
      issue(OP_SEND, 2, 32'h0000_0BAD, 0);
      wait_resp(20);
      chk("tmo_status", last_stat, STAT_TIMEOUT);
      chk("tmo_latency", resp_cyc - acc_cyc, 9);
      cyc(1);
      issue(OP_SEND, 2, 32'h0000_0600D, 0);
      ack_pulse(OP_SEND, 2, 7);
      wait_resp(5);
      chk("tmo_edge_ack_status", last_stat, STAT_OK);
      chk("tmo_edge_ack_latency", resp_cyc - acc_cyc, 9);
`else
      r0 = n_resp;
      issue(OP_SEND, 2, 32'h0000_0BAD, 0);
      cyc(20);
      chk("no_tmo_no_resp", n_resp - r0, 0);
      chk("no_tmo_enable", sender_enables, 4'b0100);
      ack_pulse(OP_SEND, 2, 0);
      wait_resp(5);
      chk("no_tmo_status", last_stat, STAT_OK);
`endif
      cyc(2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before 200000");
      $fatal(1);
   end

endmodule

// File: doc/uarc_sender.md
# uarc_sender

Outbound UARC bus engine for core0: accepts one kill/incept/send/stream request at a time from the core pipeline and selects the target bus. It drives the shared global bus lines and that bus's sender enable, holds them until the matching per-bus ack arrives, and then reports completion back to the core. It is the initiator end of the handshake whose responder end is the receiver port set on every core.

## Interface
Parameters:
- WORD_MAG, 5, log2 of word width; WORD_WIDTH = 1 << WORD_MAG
- TOTAL_BUSES, 1, number of connected buses (≤ UARC_SETS * WORD_WIDTH)
- BUS_SEL_WIDTH, WORD_WIDTH, width of the bus index field
- TIMEOUT_CYCLES, 1024, abort limit; used only with UARC_SENDER_TIMEOUT_EN

Ports:
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  core request present
- req_ready  out  1  engine accepts request this cycle
- req_op  in  2  uarc_op_t: KILL=0, INCEPT=1, SEND=2, STREAM=3
- req_bus  in  BUS_SEL_WIDTH  target bus index
- req_data  in  WORD_WIDTH  payload (SEND/STREAM)
- req_last  in  1  STREAM only: final word
- req_incept_permission, req_incept_address  in  WORD_WIDTH each  INCEPT only
- self_permission, self_address  in  WORD_WIDTH each  static core identity
- resp_valid  out  1  one-cycle completion pulse
- resp_status  out  2  OK=0, BAD_BUS=1, TIMEOUT=2
- global_kill, global_incept, global_send, global_stream  out  1 each
- global_data, global_self_permission, global_self_address, global_incept_permission, global_incept_address  out  WORD_WIDTH each
- sender_enables  out  TOTAL_BUSES  one-hot target select
- sender_kill_acks, sender_incept_acks, sender_send_acks, sender_stream_acks  in  TOTAL_BUSES each

## Operation
- States: IDLE, DRIVE, STREAM_GAP, RESP.
- IDLE: req_ready=1; the request is accepted on an edge with req_valid. Op, bus, and payload are registered.
  - If req_bus ≥ TOTAL_BUSES, go to RESP with BAD_BUS; there is no bus activity.
  - Otherwise go to DRIVE.
- DRIVE: sender_enables[bus]=1. Exactly one of global_{op} is 1. Payload and identity lines are registered and stable.
  - Completion: an edge where the ack of the same op type on the same bus index is 1.
  - Acks of other types or from other buses are ignored.
  - KILL, INCEPT, SEND, and STREAM with last: go to RESP with OK.
  - STREAM with !last: go to STREAM_GAP.
- STREAM_GAP: sender_enables[bus] stays 1 (bus stays owned); global_stream=0; req_ready=1.
  - Only req_op=STREAM is accepted, with req_bus ignored (same bus). New data and last are loaded, then go to DRIVE.
  - Other ops hold req_ready=0.
- RESP: resp_valid=1 for one cycle with status. All global strobes and enables are 0. Return to IDLE.
- Global data/identity lines hold their last values outside DRIVE; they have no meaning unless a strobe is high.
- Reset (asynchronous, any state): state=IDLE. All strobes, enables, resp_valid, and data registers are 0; req_ready=1 after release. An in-flight transaction is dropped with no resp.

## Timing
- All outputs are registered except req_ready, which is decoded from state.
- Accept at edge N. Strobe and enable are high from cycle N+1.
- Ack sampled high at edge M. Strobe drops in cycle M+1, which is also the resp_valid cycle. The engine is in IDLE (ready) at M+2.
- Minimum single-op turnaround: accept-to-resp is 2 cycles; the back-to-back accept interval is 3 cycles.
- Stream: the ack at edge M enters STREAM_GAP at M+1. A word accepted in the same cycle re-strobes at M+2.
- An ack already high in the first DRIVE cycle completes at that edge; no minimum hold is required.

## Configuration
- UARC_SENDER_TIMEOUT_EN defined: a counter clears on entry to DRIVE or STREAM_GAP and increments each cycle there.
  - When it reaches TIMEOUT_CYCLES, strobes and enables are released and the engine goes to RESP with TIMEOUT.
  - An ack on the same edge as expiry wins (OK).
- Not defined: no counter is built, the engine waits indefinitely, and TIMEOUT is never reported.

## Structure
- Shared package uarc_pkg holds:
  - uarc_op_t
  - uarc_status_t
  - the sender state enum
  - the WORD_WIDTH derivation helper
- One sub-module, onehot_decoder (index to one-hot, with in-range flag). It is the counterpart of priority_encoder and generates sender_enables and the BAD_BUS check.

## Test plan
- SEND on bus 0, data 0xDEADBEEF, ack after 3 cycles -> global_send and enable[0] high for exactly 3 cycles, data stable, one resp_valid with OK, then strobe 0.
- KILL on bus 2 (TOTAL_BUSES=4) with send_ack[2] and kill_ack[1] pulsed first -> no completion. kill_ack[2] then completes with OK; sender_enables=4'b0100 throughout.
- STREAM of 3 words 1,2,3 with last on word 3 -> enable stays high across gaps, 3 stream strobes, single resp OK. A KILL request during a gap sees req_ready=0.
- req_bus=7 with TOTAL_BUSES=4 -> no strobe or enable; resp BAD_BUS at accept+1.
- Reset asserted mid-DRIVE -> all outputs 0 asynchronously, no resp; the next request completes normally.
- With UARC_SENDER_TIMEOUT_EN and TIMEOUT_CYCLES=8, no ack -> resp TIMEOUT after 8 DRIVE cycles. An ack on the expiry edge -> OK.
